bus_arb2: RTL and testbench
===========================

Name: bus_arb2

Overview:
- Two-master, one-slave arbiter for the 16-bit-address / 8-bit-data Butterfly16 bus (cyc/we/adr/dat/ack).
- Lets two Butterfly16 cores (id 1, id 2) share one RAM/ROM bus.
- Round-robin grant, held for as long as the owning master keeps cyc asserted.
- Per-grant ack watchdog: a stalled slave produces an error-terminated cycle instead of a hang.

Parameters:
- TIMEOUT, 255: cycles of granted-but-unacked cyc before forced termination; 0 disables the watchdog.
- AW, 16: address width.
- DW, 8: data width.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- m0_cyc_i  in  1  master 0 bus request / cycle valid.
- m0_we_i  in  1  master 0 write.
- m0_adr_i  in  AW  master 0 address.
- m0_dat_i  in  DW  master 0 write data.
- m0_ack_o  out  1  master 0 transfer complete.
- m0_err_o  out  1  master 0 watchdog termination.
- m0_dat_o  out  DW  master 0 read data.
- m1_cyc_i, m1_we_i, m1_adr_i, m1_dat_i, m1_ack_o, m1_err_o, m1_dat_o: same as master 0, for master 1.
- s_cyc_o  out  1  slave cycle valid.
- s_we_o  out  1  slave write.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave transfer complete.
- gnt_o  out  2  one-hot current owner; 00 = idle.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE, last = 1 (so master 0 wins first), watchdog count = 0.
  - gnt_o = 00.
  - s_cyc_o = s_we_o = 0; s_adr_o = 0; s_dat_o = 0.
  - All mN_ack_o = mN_err_o = 0; mN_dat_o = 0.
- States: IDLE, GNT0, GNT1. gnt_o mirrors the state.
- IDLE:
  - If only master N has cyc_i = 1, go to GNTN on the next edge.
  - If both request, grant the master that is not `last`.
  - No request: stay in IDLE.
  - Arbitration latency: 1 clock from cyc_i rising to s_cyc_o rising.
- GNTN (combinational datapath):
  - s_cyc_o = mN_cyc_i; s_we_o, s_adr_o, s_dat_o = master N's inputs.
  - mN_ack_o = s_ack_i | timeout pulse.
  - mN_dat_o = s_dat_i.
  - The other master sees ack = err = 0 and dat = 0.
  - In IDLE, s_cyc_o, s_we_o, s_adr_o and s_dat_o are 0.
- Release:
  - Grant is held while mN_cyc_i = 1 (locked sequences allowed). The edge on which mN_cyc_i = 0 sets last = N.
  - If the other master requests on that edge, go directly to its grant (no idle cycle); otherwise go to IDLE.
- Watchdog (only when TIMEOUT != 0):
  - Counter width is clog2(TIMEOUT+1).
  - Clears on any s_ack_i, on any grant change, and in IDLE.
  - Increments each granted cycle with s_cyc_o = 1 and s_ack_i = 0.
  - When the count reaches TIMEOUT: mN_err_o = 1 and mN_ack_o = 1 for exactly one cycle, then the counter clears. The grant is kept until the master drops cyc.
  - If s_ack_i and the timeout coincide, the ack wins: err = 0 and the counter clears.
- Ack tied high at the slave: every cycle is a completed transfer; the watchdog never fires.
- Simultaneous request while the current owner drops cyc: switch on that edge; the new owner is the waiting master.
- Reset asserted mid-transfer: all outputs go to reset values immediately; the slave cycle is abandoned.

Decomposition:
- Shared package bf_bus_pkg holds:
  - AW/DW defaults.
  - State encoding enum arb_state_t {IDLE, GNT0, GNT1}.
  - Grant one-hot constants GNT_NONE, GNT_M0, GNT_M1.
- One sub-module: bus_watchdog (counter, clear/enable inputs, timeout pulse output). It is reusable for the single-master bus.
- The arbiter FSM and muxes stay in bus_arb2.

Test Plan:
- Reset release, then m0_cyc_i = 1, adr 0x0010, we = 1, dat 0xA5, slave ack tied 1:
  - s_cyc_o rises 1 clock later with s_adr_o = 0x0010, s_dat_o = 0xA5.
  - m0_ack_o = 1; gnt_o = 01.
  - RAM[0x010] = 0xA5.
- Both masters raise cyc on the same cycle from IDLE after reset:
  - Master 0 is granted first.
  - After m0 drops cyc, gnt_o becomes 10 on that same edge; m1_ack_o stays 0 until then.
- Both request continuously, each dropping cyc for 1 cycle after every ack: gnt_o alternates 01, 10, 01, 10 (strict round-robin).
- TIMEOUT = 4, m1 granted, s_ack_i held 0:
  - m1_err_o = 1 and m1_ack_o = 1 for 1 cycle exactly 4 cycles after s_cyc_o rose.
  - m0_err_o stays 0.
- TIMEOUT = 4, s_ack_i = 1 on the 4th cycle: m1_ack_o = 1 and m1_err_o = 0.
- Master 1 read from ROM 0xF000 (ROM[0x000] = 0x3C), m1 granted: m1_dat_o = 0x3C and m0_dat_o = 0x00. Then assert rst_i = 0 mid-cycle: s_cyc_o = 0 and gnt_o = 00 without waiting for a clock edge.

Source files
------------

// File: rtl/bf_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package : bf_bus_pkg
// Brief   : Shared Butterfly16 bus widths, arbiter state and grant encodings.
// Rev     : 1.0
// ============================================================================
package bf_bus_pkg;

    localparam int c_BF_AW = 16;
    localparam int c_BF_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage : bf_bus_pkg
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module : bus_watchdog
// Brief  : Ack watchdog; one-cycle timeout pulse after TIMEOUT unacked cycles.
// Rev    : 1.0
// ============================================================================
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic timeout_o
);

    generate
        if (TIMEOUT == 0) begin : g_wd_off
            logic w_unused;
            assign w_unused  = &{1'b0, clk_i, rst_i, clr_i, inc_i};
            assign timeout_o = 1'b0;
        end else begin : g_wd_on
            localparam int              c_CW    = $clog2(TIMEOUT + 1);
            localparam logic [c_CW-1:0] c_LIMIT = c_CW'(TIMEOUT);

            logic [c_CW-1:0] r_count;
            logic            w_hit;

            // Pulse only on a stalled cycle, so a coinciding ack suppresses it.
            assign w_hit     = inc_i && (r_count == c_LIMIT);
            assign timeout_o = w_hit;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_count <= '0;
                end else if (clr_i || w_hit) begin
                    r_count <= '0;
                end else if (inc_i) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    endgenerate

endmodule : bus_watchdog
`default_nettype wire

// File: rtl/bus_arb2.sv
`default_nettype none
// ============================================================================
// Module : bus_arb2
// Brief  : Two-master round-robin arbiter for the Butterfly16 bus with watchdog.
// Rev    : 1.0
// ============================================================================
module bus_arb2
    import bf_bus_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int AW      = c_BF_AW,
    parameter int DW      = c_BF_DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_cyc_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic [DW-1:0] m0_dat_o,
    input  logic          m1_cyc_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [DW-1:0] m1_dat_o,
    output logic          s_cyc_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last;      // 1: master 1 owned the bus most recently
    logic       w_last_nxt;
    logic       w_timeout;
    logic       w_wd_clr;
    logic       w_wd_inc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Release hands over directly to a waiting master without an idle cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = GNT0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    w_last_nxt  = 1'b0;
                    w_state_nxt = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_o    = GNT_NONE;
        s_cyc_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        case (r_state)
            GNT0: begin
                gnt_o    = GNT_M0;
                s_cyc_o  = m0_cyc_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i | w_timeout;
                m0_err_o = w_timeout;
                m0_dat_o = s_dat_i;
            end
            GNT1: begin
                gnt_o    = GNT_M1;
                s_cyc_o  = m1_cyc_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i | w_timeout;
                m1_err_o = w_timeout;
                m1_dat_o = s_dat_i;
            end
            default: begin
            end
        endcase
    end

    assign w_wd_inc = (r_state != IDLE) && s_cyc_o && !s_ack_i;
    assign w_wd_clr = (r_state == IDLE) || s_ack_i || (w_state_nxt != r_state);

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (w_wd_clr),
        .inc_i     (w_wd_inc),
        .timeout_o (w_timeout)
    );

endmodule : bus_arb2
`default_nettype wire

// File: tb/tb_bus_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_bus_arb2
// Brief  : Self-checking bench for bus_arb2 with a RAM/ROM slave and a model.
// Rev    : 1.0
// ============================================================================
module tb_bus_arb2;

    localparam int c_TIMEOUT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        m0_cyc_i, m0_we_i, m1_cyc_i, m1_we_i;
    logic [15:0] m0_adr_i, m1_adr_i;
    logic [7:0]  m0_dat_i, m1_dat_i;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [7:0]  m0_dat_o, m1_dat_o;
    logic        s_cyc_o, s_we_o, s_ack_i;
    logic [15:0] s_adr_o;
    logic [7:0]  s_dat_o, s_dat_i;
    logic [1:0]  gnt_o;
    logic        sl_ack = 1'b0;

    logic [7:0]  ram [4096] = '{default: 8'h00};
    logic [7:0]  rom [4096];

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bus_arb2 #(
        .TIMEOUT (c_TIMEOUT),
        .AW      (16),
        .DW      (8)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_we_i  (m0_we_i),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m0_dat_o (m0_dat_o),
        .m1_cyc_i (m1_cyc_i),
        .m1_we_i  (m1_we_i),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .m1_dat_o (m1_dat_o),
        .s_cyc_o  (s_cyc_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .gnt_o    (gnt_o)
    );

    // Slave: RAM below 0xF000, ROM from 0xF000, ack under bench control.
    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return (a >= 16'hF000) ? rom[a[11:0]] : ram[a[11:0]];
    endfunction

    assign s_ack_i = sl_ack;
    assign s_dat_i = mem_rd(s_adr_o);

    always @(posedge clk_i) begin
        if (s_cyc_o && s_we_o && s_ack_i && (s_adr_o < 16'hF000))
            ram[s_adr_o[11:0]] <= s_dat_o;
    end

    task automatic idle_inputs();
        m0_cyc_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = 16'h0000; m0_dat_i = 8'h00;
        m1_cyc_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = 16'h0000; m1_dat_i = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i  = 1'b0;
        sl_ack = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i    = 1'b0;
        sl_ack   = 1'b1;
        m0_cyc_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 16'h1234; m0_dat_i = 8'h77;
        m1_cyc_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 16'h4321; m1_dat_i = 8'h88;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            #1;
            checks++;
            if (gnt_o !== 2'b00) begin
                errors++; $display("FAIL rst_gnt got %b want 00", gnt_o);
            end
            checks++;
            if ({s_cyc_o, s_we_o, s_adr_o, s_dat_o} !== 26'd0) begin
                errors++; $display("FAIL rst_slave got cyc=%b we=%b adr=%h dat=%h want all 0",
                                   s_cyc_o, s_we_o, s_adr_o, s_dat_o);
            end
            checks++;
            if ({m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o} !== 20'd0) begin
                errors++; $display("FAIL rst_master got a0=%b e0=%b d0=%h a1=%b e1=%b d1=%h want all 0",
                                   m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o);
            end
        end
        idle_inputs();
        sl_ack = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        sl_ack = 1'b1;
        m0_cyc_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 16'h0010; m0_dat_i = 8'hA5;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0) begin
            errors++; $display("FAIL wr_latency s_cyc got %b want 0", s_cyc_o);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if ({s_cyc_o, s_we_o, s_adr_o, s_dat_o} !== {1'b1, 1'b1, 16'h0010, 8'hA5}) begin
            errors++; $display("FAIL wr_slave got cyc=%b we=%b adr=%h dat=%h want 1 1 0010 a5",
                               s_cyc_o, s_we_o, s_adr_o, s_dat_o);
        end
        checks++;
        if ({gnt_o, m0_ack_o, m1_ack_o} !== {2'b01, 1'b1, 1'b0}) begin
            errors++; $display("FAIL wr_ack got gnt=%b a0=%b a1=%b want 01 1 0", gnt_o, m0_ack_o, m1_ack_o);
        end
        @(negedge clk_i);
        m0_cyc_i = 1'b0;
        checks++;
        if (ram[12'h010] !== 8'hA5) begin
            errors++; $display("FAIL wr_ram got %h want a5", ram[12'h010]);
        end
        @(negedge clk_i);
        idle_inputs();
    endtask

    task automatic test_both_from_idle();
        do_reset();
        sl_ack = 1'b1;
        m0_cyc_i = 1'b1; m0_adr_i = 16'h0100;
        m1_cyc_i = 1'b1; m1_adr_i = 16'h0200;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            #1;
            checks++;
            if ({gnt_o, m0_ack_o, m1_ack_o} !== {2'b01, 1'b1, 1'b0}) begin
                errors++; $display("FAIL both_hold k=%0d got gnt=%b a0=%b a1=%b want 01 1 0",
                                   k, gnt_o, m0_ack_o, m1_ack_o);
            end
        end
        @(negedge clk_i);
        m0_cyc_i = 1'b0;
        #1;
        checks++;
        if ({gnt_o, m1_ack_o} !== {2'b01, 1'b0}) begin
            errors++; $display("FAIL both_drop got gnt=%b a1=%b want 01 0", gnt_o, m1_ack_o);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if ({gnt_o, m1_ack_o, s_adr_o} !== {2'b10, 1'b1, 16'h0200}) begin
            errors++; $display("FAIL both_switch got gnt=%b a1=%b adr=%h want 10 1 0200",
                               gnt_o, m1_ack_o, s_adr_o);
        end
        @(negedge clk_i);
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [1:0] seq[$];
        logic [1:0] prev_g;
        bit         a0, a1;
        do_reset();
        sl_ack = 1'b1;
        a0 = 1'b0; a1 = 1'b0; prev_g = 2'b00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            m0_cyc_i = !a0;
            m1_cyc_i = !a1;
            #1;
            a0 = m0_ack_o && m0_cyc_i;
            a1 = m1_ack_o && m1_cyc_i;
            if (gnt_o != prev_g) begin
                if (gnt_o != 2'b00) seq.push_back(gnt_o);
                prev_g = gnt_o;
            end
            if (i >= 1) begin
                checks++;
                if (gnt_o === 2'b00) begin
                    errors++; $display("FAIL rr_gap i=%0d got gnt=00 want non-idle", i);
                end
            end
        end
        checks++;
        if (seq.size() < 6) begin
            errors++; $display("FAIL rr_count got %0d grants want >=6", seq.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (seq[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL rr_order k=%0d got %b want %b",
                                       k, seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
        end
        @(negedge clk_i);
        idle_inputs();
    endtask

    task automatic test_timeout();
        bit e;
        do_reset();
        sl_ack = 1'b0;
        m1_cyc_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 16'h0020;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_i);
            #1;
            e = (k == c_TIMEOUT);
            checks++;
            if ({gnt_o, s_cyc_o} !== {2'b10, 1'b1}) begin
                errors++; $display("FAIL to_grant k=%0d got gnt=%b cyc=%b want 10 1", k, gnt_o, s_cyc_o);
            end
            checks++;
            if ({m1_err_o, m1_ack_o, m0_err_o, m0_ack_o} !== {e, e, 1'b0, 1'b0}) begin
                errors++; $display("FAIL to_pulse k=%0d got e1=%b a1=%b e0=%b a0=%b want %b %b 0 0",
                                   k, m1_err_o, m1_ack_o, m0_err_o, m0_ack_o, e, e);
            end
        end
        @(negedge clk_i);
        idle_inputs();
    endtask

    task automatic test_ack_wins();
        bit ea, ee;
        do_reset();
        sl_ack = 1'b0;
        m1_cyc_i = 1'b1; m1_adr_i = 16'h0030;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            sl_ack = (k == 4);
            #1;
            ea = (k == 4) || (k == 9);
            ee = (k == 9);
            checks++;
            if ({m1_ack_o, m1_err_o} !== {ea, ee}) begin
                errors++; $display("FAIL ackwin k=%0d got a1=%b e1=%b want %b %b", k, m1_ack_o, m1_err_o, ea, ee);
            end
        end
        @(negedge clk_i);
        sl_ack = 1'b0;
        idle_inputs();
    endtask

    task automatic test_read_reset();
        do_reset();
        sl_ack = 1'b1;
        m1_cyc_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 16'hF000;
        @(negedge clk_i);
        #1;
        checks++;
        if ({gnt_o, m1_dat_o, m0_dat_o} !== {2'b10, 8'h3C, 8'h00}) begin
            errors++; $display("FAIL rd_rom got gnt=%b d1=%h d0=%h want 10 3c 00", gnt_o, m1_dat_o, m0_dat_o);
        end
        #1;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({s_cyc_o, gnt_o, m1_ack_o, m1_dat_o} !== {1'b0, 2'b00, 1'b0, 8'h00}) begin
            errors++; $display("FAIL rd_async_rst got cyc=%b gnt=%b a1=%b d1=%h want 0 00 0 00",
                               s_cyc_o, gnt_o, m1_ack_o, m1_dat_o);
        end
        idle_inputs();
        sl_ack = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Reference: the owner keeps the bus while its cyc is high; a free bus goes
    // to the sole requester, or to whichever master did not own it last.
    task automatic test_random(input int n);
        int          owner, last_m, cnt, nxt, other;
        bit          cyc[2], we[2], to;
        logic [15:0] adr[2];
        logic [7:0]  dat[2];
        logic [1:0]  e_gnt;
        logic [25:0] e_slave;
        logic [7:0]  e_rd;
        bit          e_ack[2], e_err[2];
        logic [7:0]  e_dat[2];
        do_reset();
        owner = 0; last_m = 1; cnt = 0;
        cyc[0] = 1'b0; cyc[1] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 3) == 0) cyc[m] = !cyc[m];
                we[m]  = 1'($urandom_range(0, 1));
                adr[m] = ($urandom_range(0, 1) == 1) ? 16'hF000 + 16'($urandom_range(0, 15))
                                                     : 16'($urandom_range(0, 15));
                dat[m] = 8'($urandom);
            end
            sl_ack   = ($urandom_range(0, 3) == 0);
            m0_cyc_i = cyc[0]; m0_we_i = we[0]; m0_adr_i = adr[0]; m0_dat_i = dat[0];
            m1_cyc_i = cyc[1]; m1_we_i = we[1]; m1_adr_i = adr[1]; m1_dat_i = dat[1];
            #1;
            if (owner == 0) begin
                e_gnt   = 2'b00;
                e_slave = 26'd0;
                to      = 1'b0;
            end else begin
                e_gnt   = (owner == 1) ? 2'b01 : 2'b10;
                e_slave = {cyc[owner-1], we[owner-1], adr[owner-1], dat[owner-1]};
                to      = cyc[owner-1] && !sl_ack && (cnt == c_TIMEOUT);
            end
            e_rd = mem_rd(owner == 0 ? 16'h0000 : adr[owner-1]);
            for (int m = 0; m < 2; m++) begin
                e_ack[m] = (owner == m + 1) && (sl_ack || to);
                e_err[m] = (owner == m + 1) && to;
                e_dat[m] = (owner == m + 1) ? e_rd : 8'h00;
            end
            checks++;
            if (gnt_o !== e_gnt) begin
                errors++;
                if (errors < 30) $display("FAIL rnd_gnt i=%0d got %b want %b", i, gnt_o, e_gnt);
            end
            checks++;
            if ({s_cyc_o, s_we_o, s_adr_o, s_dat_o} !== e_slave) begin
                errors++;
                if (errors < 30) $display("FAIL rnd_slave i=%0d got %h want %h", i,
                                          {s_cyc_o, s_we_o, s_adr_o, s_dat_o}, e_slave);
            end
            checks++;
            if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== {e_ack[0], e_err[0], e_ack[1], e_err[1]}) begin
                errors++;
                if (errors < 30) $display("FAIL rnd_ackerr i=%0d got %b%b%b%b want %b%b%b%b", i,
                                          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o,
                                          e_ack[0], e_err[0], e_ack[1], e_err[1]);
            end
            checks++;
            if ({m0_dat_o, m1_dat_o} !== {e_dat[0], e_dat[1]}) begin
                errors++;
                if (errors < 30) $display("FAIL rnd_rdat i=%0d got %h %h want %h %h", i,
                                          m0_dat_o, m1_dat_o, e_dat[0], e_dat[1]);
            end
            nxt = owner;
            if (owner == 0) begin
                if (cyc[0] && cyc[1]) nxt = (last_m == 1) ? 1 : 2;
                else if (cyc[0])      nxt = 1;
                else if (cyc[1])      nxt = 2;
            end else if (!cyc[owner-1]) begin
                last_m = owner - 1;
                other  = (owner == 1) ? 2 : 1;
                nxt    = cyc[other-1] ? other : 0;
            end
            if (owner == 0 || sl_ack || nxt != owner || to) cnt = 0;
            else if (cyc[owner-1])                         cnt = cnt + 1;
            owner = nxt;
        end
        @(negedge clk_i);
        idle_inputs();
        sl_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h3C;
        idle_inputs();
        test_reset();
        test_single_write();
        test_both_from_idle();
        test_round_robin();
        test_timeout();
        test_ack_wins();
        test_read_reset();
        test_random(800);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bus_arb2
`default_nettype wire
